multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
// - Main control unit of the multicycle RV32I core: sequences fetch/decode/execute/writeback FSM.
// - Drives the ALU opcode, selects ALU operands, and consumes ALU flags to resolve branches.
// - Issues memory handshakes and register/PC/IR write enables.
// - Opposite end of the ALU op/flags interface; sits between instruction register, ALU and memory.
// PARAMETERS
// - XLEN  32  datapath width; informational only, no port depends on it
// PORTS
// clk          in   1  core clock
// rst          in   1  reset: synchronous, active-high
// opcode       in   7  instr[6:0] from instruction register
// funct3       in   3  instr[14:12]
// funct7b5     in   1  instr[30]
// flags        in   4  from ALU: [0]=Z, [1]=N, [2]=C (borrow on sub: 1 iff src1<src2 unsigned), [3]=V signed overflow
// mem_ready    in   1  memory accepted/completed current access
// pc_write     out  1  PC register enable
// adr_src      out  1  memory address: 0=PC, 1=ALUOut
// mem_write    out  1  store request, held until mem_ready
// mem_read     out  1  load/fetch request, held until mem_ready
// ir_write     out  1  instruction register enable
// reg_write    out  1  register file write enable
// result_src   out  2  00=ALUOut, 01=mem data, 10=ALU result
// alu_src_a    out  2  00=PC, 01=oldPC, 10=rs1
// alu_src_b    out  2  00=rs2, 01=imm, 10=const 4
// imm_src      out  2  00=I, 01=S, 10=B, 11=J (combinational from opcode)
// alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
// retire       out  1  one-cycle pulse when an instruction completes
// illegal      out  1  sticky; high in ILLEGAL state
// BEHAVIOUR
// - Moore FSM plus combinational branch/ALU decode; all outputs combinational from state and inputs.
// - Default for all outputs: 0. In rst cycle all enables forced 0; next state FETCH.
// - Reset mid-access abandons it; mem_write drops in the reset cycle.
// - FETCH: mem_read=1, adr_src=0, srcA=PC, srcB=4, add, result_src=10.
//   - ir_write=pc_write=mem_ready; stay until mem_ready; then DECODE.
// - DECODE: srcA=oldPC, srcB=imm, add (branch target -> ALUOut). Next state:
//   - lw(0000011)/sw(0100011) -> MEMADR; R(0110011) -> EXECR; I-ALU(0010011) -> EXECI
//   - jal(1101111) -> JAL; branch(1100011) -> BRANCH; else -> ILLEGAL
// - MEMADR: srcA=rs1, srcB=imm, add; lw -> MEMREAD, sw -> MEMWRITE.
// - MEMREAD: mem_read=1, adr_src=1; wait mem_ready -> MEMWB.
// - MEMWB: result_src=01, reg_write=1, retire=1 -> FETCH.
// - MEMWRITE: mem_write=1, adr_src=1; wait mem_ready; retire=1 on that cycle -> FETCH.
// - EXECR / EXECI: srcA=rs1, srcB=rs2 / imm; function decode -> ALUWB.
// - ALUWB: result_src=00, reg_write=1, retire=1 -> FETCH.
// - JAL: srcA=oldPC, srcB=4, add, result_src=00, pc_write=1 -> ALUWB (link write).
// - BRANCH: srcA=rs1, srcB=rs2, sub, result_src=00, retire=1 -> FETCH.
//   - pc_write=take, computed from the flags in the same cycle:
//   - beq Z, bne !Z, blt N^V, bge !(N^V), bltu C, bgeu !C; funct3 010/011 -> ILLEGAL
// - Function decode:
//   - funct3 000: add; sub iff R-type & funct7b5
//   - funct3 010: slt
//   - funct3 110: or
//   - funct3 111: and
//   - any other funct3 -> ILLEGAL (decided in EXEC state, no writeback)
// - ILLEGAL: all enables 0, illegal=1; exits only via rst.
// - Latencies with mem_ready tied 1:
//   - R/I/jal: 4 cycles
//   - lw: 5 cycles
//   - sw: 4 cycles
//   - branch: 3 cycles
// STRUCTURE
// - Package core_pkg holds:
//   - state_e enum: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, BRANCH, ILLEGAL
//   - ALU op constants: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
//   - opcode constants; flag index constants FLAG_Z/N/C/V
// - One sub-module ctrl_alu_dec: maps (alu_op class, funct3, funct7b5, opcode[5]) -> alu_control, bad_funct.
// TESTING
// - rst=1 for 2 cycles, mem_ready=1 -> no enables asserted; cycle after release: FETCH, ir_write=pc_write=1
// - addi opcode 0010011, funct3 000 -> states F,D,EXECI,ALUWB; alu_control 000; reg_write and retire in cycle 4
// - sub R-type, funct7b5=1 -> alu_control 001 in EXECR
// - beq with flags Z=1 -> pc_write=1 in BRANCH; Z=0 -> pc_write=0, retire=1 either way
// - blt: flags N=1,V=1 -> not taken; N=1,V=0 -> taken; bltu: C=1 -> taken
// - sw with mem_ready low 3 cycles -> mem_write held 3+1 cycles, single retire
// - rst asserted in MEMWRITE -> mem_write=0 that cycle; next state FETCH
// - opcode 1111111 -> illegal=1 from cycle 3, persists 10 cycles with no writes

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the multicycle RV32I control path.
// Holds FSM state encoding, ALU op codes, operand/result selector values and opcode map.
package core_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECR,
        EXECI,
        ALUWB,
        JAL,
        BRANCH,
        ILLEGAL
    } state_e;

    // Operation class handed to the ALU decoder: fixed add, fixed sub, or decode funct fields
    typedef enum logic [1:0] {
        ALUOP_ADD,
        ALUOP_SUB,
        ALUOP_FUNC
    } aluop_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/ctrl_alu_dec.sv
// ALU function decode: op class + funct3/funct7b5 -> alu_control, flags unsupported funct3.
// Purely combinational, zero latency, no backpressure.
module ctrl_alu_dec
    import core_pkg::*;
(
    input  aluop_e     alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op_b5,
    output logic [2:0] alu_control,
    output logic       bad_funct
);

    always_comb begin
        alu_control = ALU_ADD;
        bad_funct   = 1'b0;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNC: begin
                case (funct3)
                    // instr[30] only selects sub for register-register ops; addi ignores it
                    3'b000:  alu_control = (funct7b5 && op_b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: bad_funct   = 1'b1;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM; outputs combinational from state/inputs, 3-5 cycles per instruction.
// Memory states hold mem_read/mem_write until mem_ready; ILLEGAL is left only through rst.
module multicycle_ctrl
    import core_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic [3:0] flags,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       mem_read,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic       retire,
    output logic       illegal
);

    state_e     state;
    state_e     next_state;
    aluop_e     alu_op;
    logic [2:0] dec_control;
    logic       bad_funct;
    logic       br_take;
    logic       br_bad;

    assign alu_op = (state == EXECR || state == EXECI) ? ALUOP_FUNC :
                    (state == BRANCH)                  ? ALUOP_SUB  : ALUOP_ADD;

    ctrl_alu_dec u_alu_dec (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op_b5       (opcode[5]),
        .alu_control (dec_control),
        .bad_funct   (bad_funct)
    );

    always_comb begin
        br_take = 1'b0;
        br_bad  = 1'b0;
        case (funct3)
            3'b000:  br_take = flags[FLAG_Z];
            3'b001:  br_take = !flags[FLAG_Z];
            3'b100:  br_take = flags[FLAG_N] ^ flags[FLAG_V];
            3'b101:  br_take = !(flags[FLAG_N] ^ flags[FLAG_V]);
            3'b110:  br_take = flags[FLAG_C];
            3'b111:  br_take = !flags[FLAG_C];
            default: br_bad  = 1'b1;
        endcase
    end

    always_comb begin
        case (opcode)
            OP_STORE:  imm_src = IMM_S;
            OP_BRANCH: imm_src = IMM_B;
            OP_JAL:    imm_src = IMM_J;
            default:   imm_src = IMM_I;
        endcase
    end

    always_comb begin
        next_state  = state;
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        mem_read    = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        result_src  = RES_ALUOUT;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RS2;
        alu_control = dec_control;
        retire      = 1'b0;
        illegal     = 1'b0;
        case (state)
            FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                if (mem_ready) next_state = DECODE;
            end
            DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: next_state = MEMADR;
                    OP_RTYPE:          next_state = EXECR;
                    OP_ITYPE:          next_state = EXECI;
                    OP_JAL:            next_state = JAL;
                    OP_BRANCH:         next_state = BRANCH;
                    default:           next_state = ILLEGAL;
                endcase
            end
            MEMADR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                next_state = opcode[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem_read = 1'b1;
                adr_src  = 1'b1;
                if (mem_ready) next_state = MEMWB;
            end
            MEMWB: begin
                result_src = RES_MEM;
                reg_write  = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
            end
            MEMWRITE: begin
                mem_write = 1'b1;
                adr_src   = 1'b1;
                retire    = mem_ready;
                if (mem_ready) next_state = FETCH;
            end
            EXECR, EXECI: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = (state == EXECI) ? SRCB_IMM : SRCB_RS2;
                next_state = bad_funct ? ILLEGAL : ALUWB;
            end
            ALUWB: begin
                reg_write  = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
            end
            JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                pc_write   = 1'b1;
                next_state = ALUWB;
            end
            BRANCH: begin
                // Flags come from this cycle's rs1-rs2 subtract, so the decision resolves here
                alu_src_a  = SRCA_RS1;
                pc_write   = br_take && !br_bad;
                retire     = !br_bad;
                next_state = br_bad ? ILLEGAL : FETCH;
            end
            ILLEGAL: illegal = 1'b1;
            default: next_state = ILLEGAL;
        endcase
        if (rst) begin
            pc_write    = 1'b0;
            adr_src     = 1'b0;
            mem_write   = 1'b0;
            mem_read    = 1'b0;
            ir_write    = 1'b0;
            reg_write   = 1'b0;
            result_src  = RES_ALUOUT;
            alu_src_a   = SRCA_PC;
            alu_src_b   = SRCB_RS2;
            alu_control = ALU_ADD;
            retire      = 1'b0;
            illegal     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= next_state;
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: instruction-level schedule model with randomized instructions and stalls.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       mem_read;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic       retire;
        logic       illegal;
    } ctl_t;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BR  = 7'b1100011;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic [3:0] flags;
    logic       mem_ready;
    logic       pc_write, adr_src, mem_write, mem_read, ir_write, reg_write, retire, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;

    ctl_t got;
    ctl_t e;
    int   n_vec;
    int   n_err;

    multicycle_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .flags       (flags),
        .mem_ready   (mem_ready),
        .pc_write    (pc_write),
        .adr_src     (adr_src),
        .mem_write   (mem_write),
        .mem_read    (mem_read),
        .ir_write    (ir_write),
        .reg_write   (reg_write),
        .result_src  (result_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .imm_src     (imm_src),
        .alu_control (alu_control),
        .retire      (retire),
        .illegal     (illegal)
    );

    assign got = {pc_write, adr_src, mem_write, mem_read, ir_write, reg_write,
                  result_src, alu_src_a, alu_src_b, alu_control, retire, illegal};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] imm_ref(input logic [6:0] op);
        if (op == SW) return 2'b01;
        if (op == BR) return 2'b10;
        if (op == JL) return 2'b11;
        return 2'b00;
    endfunction

    // ALU flags as the ALU would produce them for rs1 - rs2
    function automatic logic [3:0] flags_of(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] d;
        logic [3:0]  f;
        d    = a - b;
        f[0] = (d == 32'd0);
        f[1] = d[31];
        f[2] = (a < b);
        f[3] = (a[31] != b[31]) && (d[31] != a[31]);
        return f;
    endfunction

    function automatic logic br_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) <  $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a <  b;
            default: return a >= b;
        endcase
    endfunction

    // {valid, alu_control}
    function automatic logic [3:0] alu_ref(input logic [2:0] f3, input logic f7, input logic is_r);
        case (f3)
            3'b000:  return (is_r && f7) ? 4'b1001 : 4'b1000;
            3'b010:  return 4'b1101;
            3'b110:  return 4'b1011;
            3'b111:  return 4'b1010;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic cyc(input string tag, input logic mr);
        mem_ready = mr;
        @(negedge clk);
        check(tag, 32'(got), 32'(e));
        check({tag, "_imm"}, 32'(imm_src), 32'(imm_ref(opcode)));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        e = '0;
        cyc("reset0", 1'b1);
        cyc("reset1", 1'b1);
        rst = 1'b0;
    endtask

    task automatic fetch_decode(input int fst);
        for (int i = 0; i < fst; i++) begin
            e = '0; e.mem_read = 1'b1; e.alu_src_b = 2'b10; e.result_src = 2'b10;
            cyc("fetch_wait", 1'b0);
        end
        e = '0; e.mem_read = 1'b1; e.alu_src_b = 2'b10; e.result_src = 2'b10;
        e.ir_write = 1'b1; e.pc_write = 1'b1;
        cyc("fetch", 1'b1);
        e = '0; e.alu_src_a = 2'b01; e.alu_src_b = 2'b01;
        cyc("decode", 1'b1);
    endtask

    task automatic aluwb();
        e = '0; e.reg_write = 1'b1; e.retire = 1'b1;
        cyc("aluwb", 1'b1);
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic [31:0] a, input logic [31:0] b, input int fst, input int mst);
        logic       bad;
        logic [3:0] ar;
        opcode = op; funct3 = f3; funct7b5 = f7; flags = flags_of(a, b);
        fetch_decode(fst);
        bad = 1'b0;
        case (op)
            LW, SW: begin
                e = '0; e.alu_src_a = 2'b10; e.alu_src_b = 2'b01;
                cyc("memadr", 1'b1);
                for (int i = 0; i < mst; i++) begin
                    e = '0; e.adr_src = 1'b1;
                    if (op == LW) e.mem_read = 1'b1; else e.mem_write = 1'b1;
                    cyc("mem_wait", 1'b0);
                end
                e = '0; e.adr_src = 1'b1;
                if (op == LW) e.mem_read = 1'b1; else begin e.mem_write = 1'b1; e.retire = 1'b1; end
                cyc("mem_done", 1'b1);
                if (op == LW) begin
                    e = '0; e.result_src = 2'b01; e.reg_write = 1'b1; e.retire = 1'b1;
                    cyc("memwb", 1'b1);
                end
            end
            RT, IT: begin
                ar = alu_ref(f3, f7, op == RT);
                e = '0; e.alu_src_a = 2'b10; e.alu_src_b = (op == IT) ? 2'b01 : 2'b00;
                e.alu_control = ar[3] ? ar[2:0] : 3'b000;
                cyc("exec", 1'b1);
                if (ar[3]) aluwb(); else bad = 1'b1;
            end
            JL: begin
                e = '0; e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.pc_write = 1'b1;
                cyc("jal", 1'b1);
                aluwb();
            end
            BR: begin
                bad = (f3 == 3'b010) || (f3 == 3'b011);
                e = '0; e.alu_src_a = 2'b10; e.alu_control = 3'b001;
                e.retire = !bad; e.pc_write = !bad && br_ref(f3, a, b);
                cyc("branch", 1'b1);
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            for (int i = 0; i < 10; i++) begin
                flags = 4'($urandom);
                e = '0; e.illegal = 1'b1;
                cyc("illegal", 1'($urandom));
            end
            do_reset();
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1'b1; opcode = IT; funct3 = 3'b000; funct7b5 = 1'b0; flags = 4'h0; mem_ready = 1'b1;
        do_reset();

        run_instr(IT, 3'b000, 1'b0, 32'd0, 32'd0, 0, 0);                  // addi
        run_instr(RT, 3'b000, 1'b1, 32'd0, 32'd0, 0, 0);                  // sub
        run_instr(BR, 3'b000, 1'b0, 32'd7, 32'd7, 0, 0);                  // beq taken
        run_instr(BR, 3'b000, 1'b0, 32'd7, 32'd9, 0, 0);                  // beq not taken
        run_instr(BR, 3'b100, 1'b0, 32'd1, 32'h8000_0001, 0, 0);          // blt N=1 V=1
        run_instr(BR, 3'b100, 1'b0, 32'd1, 32'd2, 0, 0);                  // blt N=1 V=0
        run_instr(BR, 3'b110, 1'b0, 32'd1, 32'd2, 0, 0);                  // bltu C=1
        run_instr(SW, 3'b010, 1'b0, 32'd0, 32'd0, 1, 3);                  // sw, 3 stall cycles
        run_instr(LW, 3'b010, 1'b0, 32'd0, 32'd0, 2, 1);
        run_instr(JL, 3'b000, 1'b0, 32'd0, 32'd0, 0, 0);

        // reset lands while a store is still waiting on memory
        opcode = SW; funct3 = 3'b010; funct7b5 = 1'b0;
        fetch_decode(0);
        e = '0; e.alu_src_a = 2'b10; e.alu_src_b = 2'b01;
        cyc("memadr", 1'b1);
        e = '0; e.adr_src = 1'b1; e.mem_write = 1'b1;
        cyc("mem_wait", 1'b0);
        rst = 1'b1; e = '0;
        cyc("rst_in_memwrite", 1'b0);
        rst = 1'b0;
        run_instr(IT, 3'b111, 1'b0, 32'd0, 32'd0, 0, 0);

        run_instr(7'b1111111, 3'b000, 1'b0, 32'd0, 32'd0, 0, 0);
        run_instr(IT, 3'b101, 1'b0, 32'd0, 32'd0, 0, 0);                  // bad funct3
        run_instr(BR, 3'b011, 1'b0, 32'd0, 32'd0, 0, 0);                  // bad branch funct3

        for (int n = 0; n < 150; n++) begin
            logic [6:0] op;
            case ($urandom_range(0, 7))
                0:       op = LW;
                1:       op = SW;
                2:       op = RT;
                3:       op = IT;
                4:       op = JL;
                5, 6:    op = BR;
                default: op = ($urandom_range(0, 1) == 0) ? 7'b1111111 : 7'b0000000;
            endcase
            run_instr(op, 3'($urandom), 1'($urandom),
                      ($urandom_range(0, 3) == 0) ? 32'd5 : $urandom,
                      ($urandom_range(0, 3) == 0) ? 32'd5 : $urandom,
                      $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
